waveform_buffer: RTL and testbench

Scrolling sample store that sits directly upstream of the waveform renderer. It accepts 8-bit ECG samples from the acquisition path and decimates them by a power of two. Decimated samples go into a circular dual-port RAM. For each display pixel it returns the sample belonging to column `hcount`, oldest sample at the left edge, as the renderer's `signal_in`. It also forwards `hcount`/`vcount` delayed to match its own latency.

---
 rtl/waveform_pkg.sv | 13 +
 rtl/sample_ram.sv | 26 ++
 rtl/waveform_buffer.sv | 175 +++++++++++++++++
 tb/tb_waveform_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_pkg.sv
// Shared widths and sample type for the waveform display path (buffer and renderer).
package waveform_pkg;

    localparam int SAMPLE_BITS = 8;
    localparam int HCOUNT_BITS = 11;
    localparam int VCOUNT_BITS = 10;
    localparam int WAVE_WIDTH  = 1024;

    typedef logic [SAMPLE_BITS-1:0] sample_t;
    typedef logic [HCOUNT_BITS-1:0] hcount_t;
    typedef logic [VCOUNT_BITS-1:0] vcount_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one registered read-first read port.
module sample_ram
    import waveform_pkg::*;
#(
    parameter int DEPTH     = WAVE_WIDTH,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  sample_t              wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output sample_t              rd_data
);

    sample_t mem [DEPTH];

    // Same-address write/read returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/waveform_buffer.sv
// Decimating circular sample buffer feeding the waveform renderer, oldest sample at column 0.
// Optional WAVEFORM_BUFFER_FREEZE_EN adds a freeze input that holds the buffer still.
module waveform_buffer
    import waveform_pkg::*;
#(
    parameter int WIDTH      = WAVE_WIDTH,
    parameter int ADDR_BITS  = 10,
    parameter int DECIM_LOG2 = 2
) (
    input  logic    clock,
    input  logic    reset,
    input  sample_t sample_in,
    input  logic    sample_valid,
    input  hcount_t hcount,
    input  vcount_t vcount,
`ifdef WAVEFORM_BUFFER_FREEZE_EN
    input  logic    freeze,
`endif
    output sample_t signal_out,
    output hcount_t hcount_d,
    output vcount_t vcount_d
);

    localparam int FILL_BITS = ADDR_BITS + 1;
    localparam logic [FILL_BITS-1:0] WIDTH_F   = FILL_BITS'(WIDTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH - 1);

    logic hold;
`ifdef WAVEFORM_BUFFER_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    // sample_valid is a one-cycle strobe with no backpressure: every strobe seen while not
    // held is consumed on that clock edge.
    logic    strobe;
    logic    wr_pend;
    logic    wr_en;
    sample_t wr_data;

    assign strobe = sample_valid & ~hold;
    assign wr_en  = wr_pend & ~hold;

    if (DECIM_LOG2 == 0) begin : g_passthru
        always_ff @(posedge clock) begin
            if (reset) begin
                wr_pend <= 1'b0;
            end else begin
                wr_pend <= strobe;
            end
            if (strobe) begin
                wr_data <= sample_in;
            end
        end
    end else begin : g_decim
        logic [SAMPLE_BITS+DECIM_LOG2-1:0] acc, acc_base, acc_sum;
        logic [DECIM_LOG2-1:0]             dcnt, dcnt_base;
        logic                              hold_q;

        // The first cycle after a release starts a fresh window.
        always_comb begin
            acc_base  = hold_q ? '0 : acc;
            dcnt_base = hold_q ? '0 : dcnt;
            acc_sum   = acc_base + (SAMPLE_BITS + DECIM_LOG2)'(sample_in);
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                acc     <= '0;
                dcnt    <= '0;
                hold_q  <= 1'b0;
                wr_pend <= 1'b0;
            end else begin
                hold_q  <= hold;
                wr_pend <= 1'b0;
                if (!hold) begin
                    acc  <= acc_base;
                    dcnt <= dcnt_base;
                    if (strobe) begin
                        dcnt <= dcnt_base + 1'b1;
                        if (&dcnt_base) begin
                            wr_pend <= 1'b1;
                            acc     <= '0;
                        end else begin
                            acc <= acc_sum;
                        end
                    end
                end
            end
            if (strobe && (&dcnt_base)) begin
                wr_data <= acc_sum[DECIM_LOG2 +: SAMPLE_BITS];
            end
        end
    end

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [FILL_BITS-1:0] fill;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            if (fill != WIDTH_F) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Frame snapshot; column 0 of the new frame already sees the values being latched.
    logic                 frame_start;
    logic [ADDR_BITS-1:0] base, base_now, base_eff;
    logic [FILL_BITS-1:0] fill_snap, fill_eff;

    assign frame_start = (hcount == '0) && (vcount == '0);
    assign base_now    = (fill == WIDTH_F) ? wr_ptr : '0;
    assign base_eff    = frame_start ? base_now : base;
    assign fill_eff    = frame_start ? fill : fill_snap;

    always_ff @(posedge clock) begin
        if (reset) begin
            base      <= '0;
            fill_snap <= '0;
        end else if (frame_start) begin
            base      <= base_now;
            fill_snap <= fill;
        end
    end

    logic [FILL_BITS-1:0] addr_sum, addr_wrap;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 col_ok, col_ok_d;
    hcount_t              hcount_q;
    vcount_t              vcount_q;
    sample_t              mem_q;

    assign addr_sum  = {1'b0, base_eff} + FILL_BITS'(hcount);
    assign addr_wrap = (addr_sum >= WIDTH_F) ? addr_sum - WIDTH_F : addr_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            col_ok   <= 1'b0;
            col_ok_d <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hcount_d <= '0;
            vcount_d <= '0;
        end else begin
            col_ok   <= 32'(hcount) < 32'(fill_eff);
            col_ok_d <= col_ok;
            hcount_q <= hcount;
            vcount_q <= vcount;
            hcount_d <= hcount_q;
            vcount_d <= vcount_q;
        end
        rd_addr <= addr_wrap[ADDR_BITS-1:0];
    end

    sample_ram #(
        .DEPTH    (WIDTH),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clock  (clock),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(mem_q)
    );

    assign signal_out = col_ok_d ? mem_q : '0;

endmodule

// File: tb/tb_waveform_buffer.sv
// Bench for waveform_buffer: raster-driven frames, spec-level model of the visible samples,
// per-cycle compare of the delayed outputs plus literal spot checks per scenario.
module tb_waveform_buffer;

  localparam int W    = 12;
  localparam int AB   = 4;
  localparam int DL   = 2;
  localparam int WIN  = 1 << DL;
  localparam int EW   = 29;
  localparam int NCOL = 16;
  localparam int NLIN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic [10:0] hcount = 11'd7;
  logic [9:0]  vcount = 10'd5;
  logic        freeze = 1'b0;
  logic [7:0]  signal_out;
  logic [10:0] hcount_d;
  logic [9:0]  vcount_d;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    hist[$];
  logic [7:0]    snap_vals[W];
  int            snap_len = 0;
  int            win_sum = 0;
  int            win_cnt = 0;
  logic          frz_q = 1'b0;
  logic [7:0]    seen[NLIN][NCOL];
  logic [7:0]    inj[4];

  waveform_buffer #(
    .WIDTH(W),
    .ADDR_BITS(AB),
    .DECIM_LOG2(DL)
  ) dut (
    .clock(clk),
    .reset(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .hcount(hcount),
    .vcount(vcount),
`ifdef WAVEFORM_BUFFER_FREEZE_EN
    .freeze(freeze),
`endif
    .signal_out(signal_out),
    .hcount_d(hcount_d),
    .vcount_d(vcount_d)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: visible display = last min(n, W) decimated samples, oldest first, latched at frame start
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        win_sum = 0;
        win_cnt = 0;
        snap_len = 0;
        frz_q = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
      end else begin
        logic [7:0] sig;
        if (hcount == 0 && vcount == 0) begin
          snap_len = hist.size();
          for (int c = 0; c < snap_len; c++) snap_vals[c] = hist[c];
        end
        if (!freeze) begin
          if (frz_q) begin
            win_sum = 0;
            win_cnt = 0;
          end
          if (sample_valid) begin
            win_sum += int'(sample_in);
            win_cnt++;
            if (win_cnt == WIN) begin
              hist.push_back(8'(win_sum / WIN));
              if (hist.size() > W) void'(hist.pop_front());
              win_sum = 0;
              win_cnt = 0;
            end
          end
        end
        frz_q = freeze;
        sig = (int'(hcount) < snap_len) ? snap_vals[hcount] : 8'd0;
        exp_q.push_back({sig, hcount, vcount});
      end
    end
  end

  // scoreboard: compare every cycle, record what each on-screen pixel showed
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        e = exp_q.pop_front();
        act = {signal_out, hcount_d, vcount_d};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL pipe: got sig=%0d h=%0d v=%0d, expected sig=%0d h=%0d v=%0d",
                   act[28:21], act[20:10], act[9:0], e[28:21], e[20:10], e[9:0]);
        end
        if (e[9:0] < NLIN && e[20:10] < NCOL) seen[e[9:0]][e[20:10]] = signal_out;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      hcount = 11'd7;
      vcount = 10'd5;
      sample_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic feed(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      hcount = 11'd5;
      vcount = 10'd5;
      sample_in = 8'(val);
      sample_valid = 1'b1;
      @(negedge clk);
    end
    idle(2);
  endtask

  task automatic run_frame(input bit inject, input bit rst_mid);
    for (int v = 0; v < NLIN; v++) begin
      for (int h = 0; h < NCOL; h++) begin
        hcount = 11'(h);
        vcount = 10'(v);
        sample_valid = 1'b0;
        rst = 1'b0;
        if (inject && v == 1 && h >= 4 && h < 8) begin
          sample_valid = 1'b1;
          sample_in = inj[h-4];
        end
        if (rst_mid && v == 1 && h == 3) rst = 1'b1;
        @(negedge clk);
      end
    end
    idle(3);
  endtask

  initial begin
    @(negedge clk);
    idle(0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // empty buffer: whole frame blank
    run_frame(1'b0, 1'b0);
    chk("empty_c0", seen[0][0], 0);
    chk("empty_c11", seen[2][11], 0);

    // one window 10,20,30,40 -> 25 at column 0 only
    feed(10, 1); feed(20, 1); feed(30, 1); feed(40, 1);
    run_frame(1'b0, 1'b0);
    chk("avg_c0", seen[0][0], 25);
    chk("avg_c1", seen[0][1], 0);

    // mid-frame write (100,101,101,101 -> 403/4 truncated = 100) hidden until next frame
    inj[0] = 8'd100; inj[1] = 8'd101; inj[2] = 8'd101; inj[3] = 8'd101;
    run_frame(1'b1, 1'b0);
    chk("midframe_hidden", seen[2][1], 0);
    chk("midframe_old", seen[2][0], 25);
    run_frame(1'b0, 1'b0);
    chk("nextframe_c1", seen[0][1], 100);
    chk("nextframe_c0", seen[0][0], 25);

    // W+3 windows of value = index: oldest-left after wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) feed(i % 256, WIN);
    run_frame(1'b0, 1'b0);
    chk("wrap_c0", seen[0][0], 3);
    chk("wrap_c5", seen[1][5], 8);
    chk("wrap_clast", seen[0][W-1], W + 2);
    chk("wrap_beyond", seen[0][W], 0);
    chk("wrap_c15", seen[2][15], 0);
    feed(15, WIN);
    feed(16, WIN);
    run_frame(1'b0, 1'b0);
    chk("scroll_c0", seen[0][0], 5);
    chk("scroll_clast", seen[1][W-1], 16);

    // reset in the middle of a full-buffer frame
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);
    chk("rst_mid_c0", seen[0][0], 0);
    chk("rst_mid_c5", seen[1][5], 0);
    chk("rst_mid_clast", seen[2][W-1], 0);

`ifdef WAVEFORM_BUFFER_FREEZE_EN
    feed(50, WIN);
    feed(60, WIN);
    feed(200, 2);
    run_frame(1'b0, 1'b0);
    freeze = 1'b1;
    for (int i = 0; i < 100; i++) feed(i, 1);
    run_frame(1'b0, 1'b0);
    chk("frz_c0", seen[0][0], 50);
    chk("frz_c1", seen[1][1], 60);
    chk("frz_c2", seen[2][2], 0);
    run_frame(1'b0, 1'b0);
    chk("frz_again_c2", seen[0][2], 0);
    freeze = 1'b0;
    idle(2);
    feed(80, WIN);
    run_frame(1'b0, 1'b0);
    chk("thaw_c2", seen[0][2], 80);
    chk("thaw_c3", seen[0][3], 0);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
